issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 The block SHALL have parameter STALL_W, default 16, meaning the width of the saturating stall counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_ins, input, 24, the fetched instruction: [23:19] opcode, [18:14] rd, [13:9] rsA, [8:4] rsB, [7:0] imm.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_ins holds a valid instruction.
REQ-006 The block SHALL have port in_ready, output, 1, meaning in_ins is accepted at this edge when in_valid is also 1.
REQ-007 The block SHALL have port ins, output, 24, the issued instruction word driven to the operand-fetch stage.
REQ-008 The block SHALL have port imm, output, 8, the immediate operand.
REQ-009 The block SHALL have port imm_sel, output, 1, selecting imm as operand B.
REQ-010 The block SHALL have port mux_sel_A, output, 2, the forwarding select for operand A: 00 register bank, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-011 The block SHALL have port mux_sel_B, output, 2, the forwarding select for operand B, encoded as mux_sel_A.
REQ-012 The block SHALL have port RW_dm, output, 5, the destination address of the instruction in the dm slot.
REQ-013 The block SHALL have port wr_dm, output, 1, asserted when the dm-slot instruction writes the register bank.
REQ-014 The block SHALL have port stall_cnt, output, STALL_W, counting load-use stall cycles.

Function
REQ-015 Opcode classes SHALL be: 00000 NOP; 00001-01111 R-type (reads rsA and rsB, writes rd); 10000-10111 I-type (reads rsA, uses imm, writes rd); 11000-11011 LOAD (reads rsA, uses imm, writes rd, late result); 11100-11111 reserved, decoded as NOP.
REQ-016 Exactly one slot SHALL issue per clock: either the accepted instruction (in_valid && in_ready) or a bubble (ins=0, NOP).
REQ-017 The issue register outputs (ins, imm, imm_sel, mux_sel_A, mux_sel_B) SHALL update at the edge the slot issues, giving one-cycle latency from acceptance.
REQ-018 A three-entry tracker {valid, wr, rd, is_load} for distances 1 (ex), 2 (dm), 3 (wb) SHALL shift by one every clock; each new entry SHALL be the slot being issued.
REQ-019 mux_sel_X SHALL be 01/10/11 when a tracker entry at distance 1/2/3 has wr=1 and rd equal to the source address; the nearest distance SHALL win; with no match the value SHALL be 00.
REQ-020 Only sources actually read per REQ-015 SHALL be compared; an unread source SHALL give mux_sel 00.
REQ-021 imm SHALL be in_ins[7:0] and imm_sel 1 for I-type and LOAD; otherwise imm SHALL be 0 and imm_sel 0.
REQ-022 Load-use hazard condition: a valid candidate reads a register equal to rd of the distance-1 entry, and that entry has is_load=1.
REQ-023 On a load-use hazard, in_ready SHALL be 0 (combinational) and a bubble SHALL issue; the next cycle the same instruction SHALL issue with select 10.
REQ-024 Each hazard cycle SHALL increment stall_cnt, saturating at all-ones.
REQ-025 When there is no hazard and reset is deasserted, in_ready SHALL be 1.
REQ-026 RW_dm and wr_dm SHALL equal the rd and wr of the distance-2 entry; a bubble or NOP SHALL have wr=0.
REQ-027 Register address 0 SHALL be forwarded like any other address.

Reset
REQ-028 While rst_n=0, all of the following SHALL be 0: outputs ins, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm, wr_dm, stall_cnt, and in_ready; all tracker entries SHALL be invalid.
REQ-029 Reset asserted mid-stall SHALL discard the pending instruction, and no forwarding to pre-reset instructions SHALL occur after release.
REQ-030 The first edge after release SHALL accept in_ins if in_valid=1.

Verification
REQ-031 Scenario back-to-back R-type: write r3, then read rsA=r3 in the next slot -> mux_sel_A=01; a third read of r3 at distance 2 -> 10, at distance 3 -> 11, at distance 4 -> 00.
REQ-032 Scenario double producer: r5 written at distances 1 and 2, consumer reads rsB=r5 -> mux_sel_B=01.
REQ-033 Scenario load-use: LOAD r7 followed by R-type reading rsA=r7 -> in_ready=0 for one cycle, bubble issued (ins=0), consumer then issues with mux_sel_A=10, stall_cnt=1.
REQ-034 Scenario immediate: I-type with imm=0x5A and rsB field equal to a fresh rd -> imm=0x5A, imm_sel=1, mux_sel_B=00, no stall.
REQ-035 Scenario bubbles: in_valid=0 for 3 cycles after writing r2, then a read of r2 -> mux_sel 00; wr_dm=0 during bubbles.
REQ-036 Scenario reset: rst_n pulsed low during a stall -> all outputs 0 immediately; after release there are no stale forwards and stall_cnt restarts at 0.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Fetch-to-issue handshake plus the issue-stage outputs seen by operand fetch,
// forwarding muxes and the dm-slot writeback logic.
interface issue_ctrl_if #(
    parameter int STALL_W = 16
);
    logic [23:0]        in_ins;
    logic               in_valid;
    logic               in_ready;
    logic [23:0]        ins;
    logic [7:0]         imm;
    logic               imm_sel;
    logic [1:0]         mux_sel_A;
    logic [1:0]         mux_sel_B;
    logic [4:0]         RW_dm;
    logic               wr_dm;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output in_ins, in_valid,
        input  in_ready, ins, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm, wr_dm, stall_cnt
    );

    modport slave (
        input  in_ins, in_valid,
        output in_ready, ins, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm, wr_dm, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// Single-issue control: decodes the fetched instruction, selects forwarding sources
// from a three-deep in-flight tracker and inserts one bubble on a load-use hazard.
module issue_ctrl #(
    parameter int STALL_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {CLS_NOP, CLS_R, CLS_I, CLS_LOAD} ins_cls_e;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
    } trk_t;

    function automatic ins_cls_e decode(input logic [4:0] op);
        if (op == 5'b00000)          return CLS_NOP;
        else if (op[4] == 1'b0)      return CLS_R;
        else if (op[4:3] == 2'b10)   return CLS_I;
        else if (op[4:2] == 3'b110)  return CLS_LOAD;
        else                         return CLS_NOP;
    endfunction

    // Nearest in-flight producer wins; unread sources never forward.
    function automatic logic [1:0] fwd_sel(input logic rd_en, input logic [4:0] src,
                                           input trk_t t_ex, input trk_t t_dm, input trk_t t_wb);
        if (!rd_en)                                   return 2'b00;
        else if (t_ex.valid && t_ex.wr && t_ex.rd == src) return 2'b01;
        else if (t_dm.valid && t_dm.wr && t_dm.rd == src) return 2'b10;
        else if (t_wb.valid && t_wb.wr && t_wb.rd == src) return 2'b11;
        else                                          return 2'b00;
    endfunction

    trk_t               r_trk_ex, r_trk_dm, r_trk_wb;
    logic               r_ex_is_load;
    logic [23:0]        r_ins;
    logic [7:0]         r_imm;
    logic               r_imm_sel;
    logic [1:0]         r_sel_a, r_sel_b;
    logic [STALL_W-1:0] r_stall_cnt;

    ins_cls_e    w_cls;
    logic [4:0]  w_rd, w_rs_a, w_rs_b;
    logic        w_reads_a, w_reads_b;
    logic        w_hazard, w_ready, w_accept;
    trk_t        w_new_trk;
    logic        w_new_is_load;
    logic [23:0] w_ins;
    logic [7:0]  w_imm;
    logic        w_imm_sel;
    logic [1:0]  w_sel_a, w_sel_b;

    assign w_cls     = decode(bus.in_ins[23:19]);
    assign w_rd      = bus.in_ins[18:14];
    assign w_rs_a    = bus.in_ins[13:9];
    assign w_rs_b    = bus.in_ins[8:4];
    assign w_reads_a = (w_cls != CLS_NOP);
    assign w_reads_b = (w_cls == CLS_R);

    // A load result is not ready for a consumer issuing directly behind it.
    assign w_hazard = bus.in_valid && r_ex_is_load &&
                      ((w_reads_a && w_rs_a == r_trk_ex.rd) ||
                       (w_reads_b && w_rs_b == r_trk_ex.rd));

    assign w_ready  = rst_n && !w_hazard;
    assign w_accept = bus.in_valid && w_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_new_trk     = '0;
        w_new_is_load = 1'b0;
        w_ins         = '0;
        w_imm         = '0;
        w_imm_sel     = 1'b0;
        w_sel_a       = 2'b00;
        w_sel_b       = 2'b00;
        if (w_accept) begin
            w_new_trk.valid = 1'b1;
            w_new_trk.wr    = (w_cls != CLS_NOP);
            w_new_trk.rd    = w_rd;
            w_new_is_load   = (w_cls == CLS_LOAD);
            w_ins           = bus.in_ins;
            w_sel_a         = fwd_sel(w_reads_a, w_rs_a, r_trk_ex, r_trk_dm, r_trk_wb);
            w_sel_b         = fwd_sel(w_reads_b, w_rs_b, r_trk_ex, r_trk_dm, r_trk_wb);
            if (w_cls == CLS_I || w_cls == CLS_LOAD) begin
                w_imm     = bus.in_ins[7:0];
                w_imm_sel = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk_ex     <= '0;
            r_trk_dm     <= '0;
            r_trk_wb     <= '0;
            r_ex_is_load <= 1'b0;
            r_ins        <= '0;
            r_imm        <= '0;
            r_imm_sel    <= 1'b0;
            r_sel_a      <= 2'b00;
            r_sel_b      <= 2'b00;
            r_stall_cnt  <= '0;
        end else begin
            r_trk_wb     <= r_trk_dm;
            r_trk_dm     <= r_trk_ex;
            r_trk_ex     <= w_new_trk;
            r_ex_is_load <= w_new_is_load;
            r_ins        <= w_ins;
            r_imm        <= w_imm;
            r_imm_sel    <= w_imm_sel;
            r_sel_a      <= w_sel_a;
            r_sel_b      <= w_sel_b;
            if (w_hazard && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.ins       = r_ins;
    assign bus.imm       = r_imm;
    assign bus.imm_sel   = r_imm_sel;
    assign bus.mux_sel_A = r_sel_a;
    assign bus.mux_sel_B = r_sel_b;
    assign bus.RW_dm     = r_trk_dm.rd;
    assign bus.wr_dm     = r_trk_dm.valid && r_trk_dm.wr;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: forwarding distances, load-use stall, immediates,
// bubbles, register 0, reserved opcodes, stall saturation and reset during a stall.
module tb_issue_ctrl;
    localparam int SW = 2;
    localparam logic [4:0] OP_R = 5'h01, OP_I = 5'h10, OP_LD = 5'h18, OP_RSV = 5'h1C;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    issue_ctrl_if #(.STALL_W(SW)) bus ();
    issue_ctrl #(.STALL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mkr(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 4'h0};
    endfunction

    function automatic logic [23:0] mki(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [7:0] imm);
        return {op, rd, ra, 1'b0, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [23:0] w, input logic v);
        @(negedge clk);
        bus.in_ins   = w;
        bus.in_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [23:0] w, input logic v, input logic rdy,
                        input logic [23:0] e_ins, input logic [7:0] e_imm, input logic e_isel,
                        input logic [1:0] e_a, input logic [1:0] e_b);
        drive(w, v);
        check({tag, ".in_ready"}, bus.in_ready, rdy);
        tick();
        check({tag, ".ins"}, bus.ins, e_ins);
        check({tag, ".imm"}, bus.imm, e_imm);
        check({tag, ".imm_sel"}, bus.imm_sel, e_isel);
        check({tag, ".sel_A"}, bus.mux_sel_A, e_a);
        check({tag, ".sel_B"}, bus.mux_sel_B, e_b);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ins"}, bus.ins, 0);
        check({tag, ".imm"}, bus.imm, 0);
        check({tag, ".imm_sel"}, bus.imm_sel, 0);
        check({tag, ".sel_A"}, bus.mux_sel_A, 0);
        check({tag, ".sel_B"}, bus.mux_sel_B, 0);
        check({tag, ".RW_dm"}, bus.RW_dm, 0);
        check({tag, ".wr_dm"}, bus.wr_dm, 0);
        check({tag, ".stall_cnt"}, bus.stall_cnt, 0);
        check({tag, ".in_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        logic [23:0] w;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_ins   = '0;
        bus.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Release and present the first instruction together: it is taken at the first edge.
        w = mkr(OP_R, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_ins   = w;
        bus.in_valid = 1'b1;
        #1;
        check("s1.in_ready", bus.in_ready, 1);
        tick();
        check("s1.ins", bus.ins, w);
        check("s1.sel_A", bus.mux_sel_A, 0);

        w = mkr(OP_R, 5'd4, 5'd3, 5'd0);  step("s2", w, 1, 1, w, 8'h00, 0, 2'b01, 2'b00);
        check("s2.RW_dm", bus.RW_dm, 3);
        check("s2.wr_dm", bus.wr_dm, 1);
        w = mkr(OP_R, 5'd6, 5'd3, 5'd4);  step("s3", w, 1, 1, w, 8'h00, 0, 2'b10, 2'b01);
        w = mkr(OP_R, 5'd8, 5'd3, 5'd0);  step("s4", w, 1, 1, w, 8'h00, 0, 2'b11, 2'b00);
        w = mkr(OP_R, 5'd9, 5'd3, 5'd10); step("s5", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);

        // Double producer of r5: nearest distance wins.
        w = mkr(OP_R, 5'd5, 5'd11, 5'd12); step("s6", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd5, 5'd13, 5'd14); step("s7", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd1, 5'd15, 5'd5);  step("s8", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b01);

        // I-type whose rsB field aliases r5: not a read, so no forward.
        w = mki(OP_I, 5'd20, 5'd9, 8'h5A); step("s9_imm", w, 1, 1, w, 8'h5A, 1, 2'b00, 2'b00);
        check("s9.stall_cnt", bus.stall_cnt, 0);

        // Load-use: one bubble, then the consumer reissues from the dm slot.
        w = mki(OP_LD, 5'd7, 5'd2, 8'h03); step("s10_ld", w, 1, 1, w, 8'h03, 1, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd10, 5'd7, 5'd20);
        step("s11_bubble", w, 1, 0, 24'h0, 8'h00, 0, 2'b00, 2'b00);
        check("s11_bubble.stall_cnt", bus.stall_cnt, 1);
        check("s11_bubble.RW_dm", bus.RW_dm, 7);
        check("s11_bubble.wr_dm", bus.wr_dm, 1);
        step("s11_reissue", w, 1, 1, w, 8'h00, 0, 2'b10, 2'b11);
        check("s11_reissue.stall_cnt", bus.stall_cnt, 1);
        check("s11_reissue.wr_dm", bus.wr_dm, 0);

        // Idle cycles after writing r2 age it out of the tracker.
        w = mkr(OP_R, 5'd2, 5'd0, 5'd0); step("s12", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);
        check("s12.RW_dm", bus.RW_dm, 10);
        step("idle1", w, 0, 1, 24'h0, 8'h00, 0, 2'b00, 2'b00);
        check("idle1.RW_dm", bus.RW_dm, 2);
        check("idle1.wr_dm", bus.wr_dm, 1);
        step("idle2", w, 0, 1, 24'h0, 8'h00, 0, 2'b00, 2'b00);
        check("idle2.wr_dm", bus.wr_dm, 0);
        step("idle3", w, 0, 1, 24'h0, 8'h00, 0, 2'b00, 2'b00);
        check("idle3.wr_dm", bus.wr_dm, 0);
        w = mkr(OP_R, 5'd11, 5'd2, 5'd2); step("s13", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);

        // Register 0 forwards; a reserved opcode neither reads nor writes.
        w = mkr(OP_R, 5'd0, 5'd1, 5'd1);    step("s14", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd12, 5'd0, 5'd0);   step("s15_r0", w, 1, 1, w, 8'h00, 0, 2'b01, 2'b01);
        w = mkr(OP_RSV, 5'd12, 5'd0, 5'd0); step("s16_rsv", w, 1, 1, w, 8'h00, 0, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd13, 5'd12, 5'd12); step("s17", w, 1, 1, w, 8'h00, 0, 2'b10, 2'b10);

        // Three more load-use stalls drive the 2-bit counter to saturation.
        for (int i = 0; i < 3; i++) begin
            w = mki(OP_LD, 5'd7, 5'd1, 8'h00);
            step("sat_ld", w, 1, 1, w, 8'h00, 1, 2'b00, 2'b00);
            w = mkr(OP_R, 5'd14, 5'd7, 5'd7);
            step("sat_bubble", w, 1, 0, 24'h0, 8'h00, 0, 2'b00, 2'b00);
            check("sat.stall_cnt", bus.stall_cnt, (i + 2 > 3) ? 3 : i + 2);
            step("sat_reissue", w, 1, 1, w, 8'h00, 0, 2'b10, 2'b10);
        end

        // Reset pulsed during a stall discards the consumer and all tracker state.
        w = mki(OP_LD, 5'd7, 5'd3, 8'h00); step("rs_ld", w, 1, 1, w, 8'h00, 1, 2'b00, 2'b00);
        w = mkr(OP_R, 5'd15, 5'd7, 5'd7);
        drive(w, 1);
        check("rs_stall.in_ready", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rs_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rs_rel.in_ready", bus.in_ready, 1);
        tick();
        check("rs_rel.ins", bus.ins, w);
        check("rs_rel.sel_A", bus.mux_sel_A, 0);
        check("rs_rel.sel_B", bus.mux_sel_B, 0);
        check("rs_rel.stall_cnt", bus.stall_cnt, 0);
        check("rs_rel.wr_dm", bus.wr_dm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
